// File: rtl/conv_kernel_window.sv
// Sliding KxKxCH window assembler: shifts in one K-pixel column per accepted
// transfer and presents a full window once K columns of the current line are in.
module conv_kernel_window #(
  parameter int PIXEL_W = 8,
  parameter int K       = 3,
  parameter int CH      = 1,
  parameter int POS_W   = 16
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       col_vld_i,
  output logic                       col_rdy_o,
  input  logic                       col_sol_i,
  input  logic [1:0]                 col_stride_i,
  input  logic [POS_W-1:0]           col_pos_i,
  input  logic [K*CH*PIXEL_W-1:0]    col_dat_i,
  output logic                       kernel_vld_o,
  input  logic                       kernel_rdy_i,
  output logic [K*K*CH*PIXEL_W-1:0]  kernel_dat_o,
  output logic [POS_W-1:0]           kernel_pos_o
);

  localparam int COL_W = K * CH * PIXEL_W;
  localparam int WIN_W = K * COL_W;
  localparam int FC_W  = $clog2(K + 1);
  localparam logic [FC_W-1:0] FCNT_FULL = FC_W'(K);

  logic [WIN_W-1:0] win_q;
  logic [POS_W-1:0] pos_q;
  logic [FC_W-1:0]  fcnt_q;
  logic [FC_W-1:0]  fcnt_step;
  logic [1:0]       sreg_q;
  logic [1:0]       sreg_eff;
  logic [1:0]       sph_q;
  logic [1:0]       sph_cur;
  logic [1:0]       sph_inc;
  logic             vld_q;
  logic             vld_next;
  logic             accept;
  logic             complete;
  logic             emit;

  // Draining the output and accepting a new column may share a cycle.
  assign col_rdy_o = ~vld_q | kernel_rdy_i;
  assign accept    = col_vld_i & col_rdy_o;

  always_comb begin
    fcnt_step = fcnt_q;
    if (col_sol_i) begin
      fcnt_step = FC_W'(1);
    end else if (fcnt_q != FCNT_FULL) begin
      fcnt_step = fcnt_q + FC_W'(1);
    end
  end

  // A start-of-line column loads a fresh stride and restarts the phase at 0.
  always_comb begin
    sreg_eff = sreg_q;
    sph_cur  = sph_q;
    if (col_sol_i) begin
      sreg_eff = (col_stride_i == 2'd0) ? 2'd1 : col_stride_i;
      sph_cur  = 2'd0;
    end
  end

  always_comb begin
    sph_inc = sph_cur + 2'd1;
    if (sph_inc == sreg_eff) begin
      sph_inc = 2'd0;
    end
  end

  assign complete = accept && (fcnt_step == FCNT_FULL);
  assign emit     = complete && (sph_cur == 2'd0);

  always_comb begin
    vld_next = vld_q;
    if (accept) begin
      vld_next = emit;
    end else if (kernel_rdy_i) begin
      vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      win_q  <= '0;
      pos_q  <= '0;
      fcnt_q <= '0;
      sreg_q <= 2'd1;
      sph_q  <= 2'd0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_next;
      if (accept) begin
        // Newest column enters at the top; column 0 (oldest) falls off the bottom.
        win_q  <= {col_dat_i, win_q[WIN_W-1:COL_W]};
        pos_q  <= col_pos_i;
        fcnt_q <= fcnt_step;
        sreg_q <= sreg_eff;
        sph_q  <= complete ? sph_inc : sph_cur;
      end
    end
  end

  assign kernel_vld_o = vld_q;
  assign kernel_dat_o = win_q;
  assign kernel_pos_o = pos_q;

endmodule

// File: doc/conv_kernel_window.md
# conv_kernel_window

Parametrised successor to the fixed-size convolution kernel assembler: accepts one K-pixel column per transfer (one pixel per kernel row, CH channels each) and builds a sliding K×K×CH window. Adds per-line fill tracking, runtime horizontal stride (1–3) and full valid/ready backpressure on both sides. It sits between the column/line-buffer stage and the convolution MAC array; the window register is the output register.

## Interface

Parameters:
- PIXEL_W, 8, bits per pixel per channel
- K, 3, kernel diameter (rows = columns = K), legal 2..9
- CH, 1, channels per pixel, legal 1..4
- POS_W, 16, width of column position tag

Ports:
- clk  in  1  clock; all state updates on rising edge
- arst_n  in  1  reset, synchronous, active-low; sampled on rising edge of clk
- col_vld_i  in  1  input column valid
- col_rdy_o  out  1  input column ready
- col_sol_i  in  1  column is the first of a new line
- col_stride_i  in  2  horizontal stride; sampled only on an accepted col_sol_i column; 0 treated as 1
- col_pos_i  in  POS_W  position tag of this column
- col_dat_i  in  K*CH*PIXEL_W  row r, channel ch at bit offset (r*CH+ch)*PIXEL_W
- kernel_vld_o  out  1  window valid
- kernel_rdy_i  in  1  window ready
- kernel_dat_o  out  K*K*CH*PIXEL_W  column c (0 = oldest), row r, channel ch at offset ((c*K+r)*CH+ch)*PIXEL_W
- kernel_pos_o  out  POS_W  col_pos_i of the newest column (c = K-1) in the window

## Operation

- accept = col_vld_i & col_rdy_o; col_rdy_o = ~kernel_vld_o | kernel_rdy_i (combinational).
- State: window register win[0..K-1], fill count fcnt (0..K, saturating), stride register sreg (1..3), stride phase sph (0..sreg-1), pos register, kernel_vld_o flop.
- On accept: win[c] <= win[c+1] for c < K-1; win[K-1] <= col_dat_i; pos <= col_pos_i.
- fcnt_next = col_sol_i ? 1 : min(fcnt+1, K).
- On accept with col_sol_i: sreg <= (col_stride_i==0 ? 1 : col_stride_i); sph <= 0.
- Window-complete event: accept & fcnt_next == K. On event: emit if sph == 0 (current, or 0 if col_sol_i); sph <= (sph+1) mod sreg.
- kernel_vld_o next: on accept = window-complete & emit; else if kernel_rdy_i = 0; else holds.
- Columns older than the last col_sol_i never appear in an emitted window (fcnt restart guarantees K fresh columns).
- With K=1 excluded (K≥2), the first emitted window of a line is after its K-th column.
- Channels are carried opaquely; no arithmetic on pixel data.

## Timing

- Reset (arst_n=0 at edge): kernel_vld_o=0, kernel_dat_o=0, kernel_pos_o=0, fcnt=0, sreg=1, sph=0; col_rdy_o=1 immediately after.
- Latency: window appears on kernel_vld_o the cycle after accepting its K-th column.
- Throughput: one column per cycle with kernel_rdy_i=1; output drain and new accept in the same cycle are permitted (no bubble).
- Stall: kernel_vld_o=1 & kernel_rdy_i=0 forces col_rdy_o=0; kernel_dat_o, kernel_pos_o, all state held stable until drained.
- kernel_vld_o never drops without a handshake (kernel_rdy_i=1) or reset.
- Accepted non-emitting column (fill or stride skip) with kernel_vld_o=0: kernel_vld_o stays 0; dat/pos update but are don't-care.
- col_sol_i on a column when fcnt<K: fill restarts at 1; partial prior line discarded.
- col_stride_i ignored on non-sol columns; changing it mid-line has no effect.
- Reset mid-stall: window dropped, kernel_vld_o=0 next cycle, no further output until K new columns (first must carry col_sol_i or fill counts from 0).
- No input sampled when col_vld_i=0; col_dat_i/col_pos_i/col_sol_i are don't-care then.

## Test plan

- Reset: hold arst_n=0 2 cycles with col_vld_i=1 -> kernel_vld_o=0, kernel_dat_o=0, kernel_pos_o=0, col_rdy_o=1, nothing captured.
- Fill, K=3, stride 1: push pos 0..4 (sol on pos 0), data column n = all pixels n+1, rdy=1 -> kernel_vld_o low after pos 0,1; high after pos 2,3,4 with kernel_pos_o 2,3,4 and columns {1,2,3},{2,3,4},{3,4,5}.
- Stride 2: sol with col_stride_i=2, push pos 0..6 -> exactly 3 windows, kernel_pos_o 2,4,6; col_stride_i=0 on sol behaves as stride 1.
- Backpressure: after first window, kernel_rdy_i=0 for 4 cycles with col_vld_i=1 -> col_rdy_o=0, dat/pos stable; release -> remaining windows in order, none lost or duplicated.
- Line restart: 4 columns of line A, then sol column pos 0 of line B, 2 more -> next window pos 2 contains only line B data; no window mixes lines.
- Reset mid-operation: assert arst_n=0 while kernel_vld_o=1 & kernel_rdy_i=0 -> kernel_vld_o=0 next cycle; subsequent 3-column line produces first window on its 3rd column.
